// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants and types for the video-memory controller.
//   - ColsDefault / RowsDefault : default text geometry
//   - CmdPage                   : cpu_addr[19:12] value that selects the command register
//   - OpClear / OpScroll        : command opcodes in cpu_din[1:0]
//   - state_e                   : engine FSM encoding
package vmem_pkg;

  localparam int unsigned ColsDefault = 70;
  localparam int unsigned RowsDefault = 30;

  localparam logic [7:0] CmdPage = 8'hFF;

  localparam logic [1:0] OpClear  = 2'b01;
  localparam logic [1:0] OpScroll = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StScrRd,
    StScrWr,
    StFill
  } state_e;

endpackage

// File: rtl/vmem_walker.sv
// vmem_walker: row-major (row, col) cursor for the video-memory engine.
//   clock, reset   : system clock, asynchronous active-high reset
//   clear          : return the cursor to (0, 0)
//   step           : advance one cell; col wraps at COLS-1 into the next row
//   last_row_limit : row on which done is flagged
//   row, col       : current cursor
//   done           : cursor sits on (last_row_limit, COLS-1)
module vmem_walker
  import vmem_pkg::*;
#(
  parameter int unsigned COLS = ColsDefault,
  parameter int unsigned ROWS = RowsDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic [4:0] last_row_limit,
  output logic [4:0] row,
  output logic [6:0] col,
  output logic       done
);

  localparam logic [6:0] LastCol = 7'(COLS - 1);

  logic [4:0] row_q;
  logic [6:0] col_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= 5'd0;
      col_q <= 7'd0;
    end else if (clear) begin
      row_q <= 5'd0;
      col_q <= 7'd0;
    end else if (step) begin
      if (col_q == LastCol) begin
        col_q <= 7'd0;
        // The final step of a pass runs row past the limit; the FSM leaves the
        // writing state on that same edge, so the out-of-range row is never used.
        row_q <= row_q + 5'd1;
      end else begin
        col_q <= col_q + 7'd1;
      end
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign done = (col_q == LastCol) && (row_q == last_row_limit);

endmodule

// File: rtl/vmem_ctrl.sv
// vmem_ctrl: text video-memory controller with CLEAR and SCROLL engine.
//   clock, reset       : system clock, asynchronous active-high reset
//   cpu_we             : CPU store strobe (already qualified for the region)
//   cpu_addr, cpu_din  : CPU store address / data; page 8'hFF is the command register
//   vm_we, vm_waddr,
//   vm_wdata           : video-memory write port (CPU stores win over the engine)
//   vm_raddr, vm_rdata : engine read port, synchronous RAM (data one cycle later)
//   status             : {30'b0, err, busy}
module vmem_ctrl
  import vmem_pkg::*;
#(
  parameter int unsigned COLS = ColsDefault,
  parameter int unsigned ROWS = RowsDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic        vm_we,
  output logic [11:0] vm_waddr,
  output logic [7:0]  vm_wdata,
  output logic [11:0] vm_raddr,
  input  logic [7:0]  vm_rdata,
  output logic [31:0] status
);

  state_e      state_q;
  logic [7:0]  fill_q;
  logic [7:0]  hold_q;
  logic        rd_pending_q;
  logic        err_q;
  logic [11:0] raddr_q;

  logic        cmd_hit;
  logic        cpu_wr;
  logic        op_clear;
  logic        op_scroll;
  logic        op_valid;
  logic        err_clr;
  logic        busy;
  logic        stall;

  logic        walk_clear;
  logic        walk_step;
  logic [4:0]  last_row_limit;
  logic [4:0]  row;
  logic [6:0]  col;
  logic        walk_done;

  logic        eng_we;
  logic [7:0]  eng_data;

  // Address/data bits with no function in this block.
  logic unused_cpu_bits;
  assign unused_cpu_bits = ^{cpu_addr[31:20], cpu_din[30:16]};

  // ---------------------------------------------------------------------------
  // CPU decode
  // ---------------------------------------------------------------------------
  assign cmd_hit   = cpu_we && (cpu_addr[19:12] == CmdPage);
  assign cpu_wr    = cpu_we && (cpu_addr[19:12] != CmdPage);
  assign op_clear  = cmd_hit && (cpu_din[1:0] == OpClear);
  assign op_scroll = cmd_hit && (cpu_din[1:0] == OpScroll);
  assign op_valid  = op_clear || op_scroll;
  assign err_clr   = cmd_hit && cpu_din[31];

  assign busy  = (state_q != StIdle);
  assign stall = cpu_wr;

  // ---------------------------------------------------------------------------
  // Walker control and engine write request
  // ---------------------------------------------------------------------------
  always_comb begin
    walk_clear     = (state_q == StIdle) && op_valid;
    walk_step      = 1'b0;
    eng_we         = 1'b0;
    eng_data       = fill_q;
    last_row_limit = 5'(ROWS - 1);
    unique case (state_q)
      StClr, StFill: begin
        walk_step = !stall;
        eng_we    = !stall;
      end
      StScrRd: begin
        last_row_limit = 5'(ROWS - 2);
      end
      StScrWr: begin
        last_row_limit = 5'(ROWS - 2);
        walk_step      = !stall;
        eng_we         = !stall;
        // Read data is only registered into hold_q at the end of the first
        // SCR_WR cycle, so that cycle writes straight from the RAM output.
        eng_data       = rd_pending_q ? vm_rdata : hold_q;
      end
      default: ;
    endcase
  end

  vmem_walker #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_walker (
    .clock          (clock),
    .reset          (reset),
    .clear          (walk_clear),
    .step           (walk_step),
    .last_row_limit (last_row_limit),
    .row            (row),
    .col            (col),
    .done           (walk_done)
  );

  // Read address follows the engine only in SCR_RD and holds otherwise.
  assign vm_raddr = (state_q == StScrRd) ? {row + 5'd1, col} : raddr_q;

  // ---------------------------------------------------------------------------
  // Write-port mux: CPU store has priority, idle port drives zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    vm_we    = 1'b0;
    vm_waddr = 12'd0;
    vm_wdata = 8'd0;
    if (cpu_wr) begin
      vm_we    = 1'b1;
      vm_waddr = cpu_addr[11:0];
      vm_wdata = cpu_din[7:0];
    end else if (eng_we) begin
      vm_we    = 1'b1;
      vm_waddr = {row, col};
      vm_wdata = eng_data;
    end
  end

  assign status = {30'd0, err_q, busy};

  // ---------------------------------------------------------------------------
  // FSM and engine registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fill_q       <= 8'd0;
      hold_q       <= 8'd0;
      rd_pending_q <= 1'b0;
      err_q        <= 1'b0;
      raddr_q      <= 12'd0;
    end else begin
      raddr_q      <= vm_raddr;
      // A stalled SCR_RD re-reads the same address, so capturing every cycle
      // after SCR_RD is always the data for the cell about to be written.
      rd_pending_q <= (state_q == StScrRd);
      if (rd_pending_q) begin
        hold_q <= vm_rdata;
      end

      if (err_clr) begin
        err_q <= 1'b0;
      end else if (op_valid && busy) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (op_clear) begin
            state_q <= StClr;
            fill_q  <= cpu_din[15:8];
          end else if (op_scroll) begin
            state_q <= StScrRd;
            fill_q  <= cpu_din[15:8];
          end
        end
        StClr: begin
          if (!stall && walk_done) begin
            state_q <= StIdle;
          end
        end
        StScrRd: begin
          if (!stall) begin
            state_q <= StScrWr;
          end
        end
        StScrWr: begin
          // The wrapping step after (ROWS-2, COLS-1) lands on (ROWS-1, 0).
          if (!stall) begin
            state_q <= walk_done ? StFill : StScrRd;
          end
        end
        StFill: begin
          if (!stall && walk_done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
